// File: rtl/fpq_led8_clk_div.sv
// Divider: counts 0..HALF_COUNT-1, toggles clk_1hz on each wrap, and flags
// the wrap that takes clk_1hz from 0 to 1 as the chaser step event.
module fpq_led8_clk_div #(
  parameter int HALF_COUNT = 25_000_000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_1hz,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_LAST);
  // Step on the same edge that clk_1hz rises, so no extra latency to the LEDs.
  assign tick = wrap & ~clk_1hz;

  // Free-running half-period counter and divided clock toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_1hz <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      clk_1hz <= ~clk_1hz;
    end else begin
      cnt     <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/fpq_led8.sv
// Board-top clock divider and 8-LED back-and-forth chaser. Everything runs on
// clk_50mhz; clk_1hz is only an output.
module fpq_led8 #(
  parameter int HALF_COUNT = 25_000_000,
  parameter int CNT_W      = 25
) (
  input  logic       clk_50mhz,
  input  logic       start,
  output logic       clk_1hz,
  output logic [7:0] led
);

  localparam logic [7:0] LED_FIRST = 8'h01;
  localparam logic [7:0] LED_LAST  = 8'h80;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t       state_q, state_d;
  logic [7:0] led_q, led_d;
  logic       tick;
  logic       one_hot;

  fpq_led8_clk_div #(
    .HALF_COUNT(HALF_COUNT),
    .CNT_W     (CNT_W)
  ) u_div (
    .clk    (clk_50mhz),
    .rst_n  (start),
    .clk_1hz(clk_1hz),
    .tick   (tick)
  );

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign one_hot = (led_q != 8'h00) && ((led_q & (led_q - 8'h01)) == 8'h00);

  // Direction and LED position registers.
  always_ff @(posedge clk_50mhz or negedge start) begin
    if (!start) begin
      state_q <= UP;
      led_q   <= LED_FIRST;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
    end
  end

  // Shift one place per tick, flipping direction as an end is reached so the
  // end positions are shown for a single step. Illegal patterns recover to 01.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    if (tick) begin
      if (!one_hot) begin
        led_d   = LED_FIRST;
        state_d = UP;
      end else if (state_q == UP) begin
        led_d = led_q << 1;
        if (led_d == LED_LAST) state_d = DOWN;
      end else begin
        led_d = led_q >> 1;
        if (led_d == LED_FIRST) state_d = UP;
      end
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_fpq_led8.sv
// Bench for fpq_led8 with HALF_COUNT = 4: reset hold, divider timing, chaser
// sequence with bounces, one-hot invariant, and asynchronous reset mid-run.
module tb_fpq_led8;

  logic       clk_50mhz;
  logic       start;
  logic       clk_1hz;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  fpq_led8 #(.HALF_COUNT(4), .CNT_W(3)) dut (
    .clk_50mhz(clk_50mhz),
    .start    (start),
    .clk_1hz  (clk_1hz),
    .led      (led)
  );

  // Rising edges at 20, 40, 60 ... so the 50 ns release lands between edges.
  initial clk_50mhz = 1'b1;
  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct {
    int         edge_n;
    logic       exp_clk;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[16];

  // 14-step sequence indexed by number of ticks taken.
  logic [7:0] seq [14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after edge e counted from release.
  function automatic logic exp_clk_at(input int e);
    return ((e / 4) % 2) == 1;
  endfunction

  function automatic logic [7:0] exp_led_at(input int e);
    int ticks;
    ticks = ((e / 4) + 1) / 2;
    return seq[ticks % 14];
  endfunction

  initial begin
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
            8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    vecs[0]  = '{1,   1'b0, 8'h01};
    vecs[1]  = '{3,   1'b0, 8'h01};
    vecs[2]  = '{4,   1'b1, 8'h02};
    vecs[3]  = '{7,   1'b1, 8'h02};
    vecs[4]  = '{8,   1'b0, 8'h02};
    vecs[5]  = '{11,  1'b0, 8'h02};
    vecs[6]  = '{12,  1'b1, 8'h04};
    vecs[7]  = '{16,  1'b0, 8'h04};
    vecs[8]  = '{44,  1'b1, 8'h40};
    vecs[9]  = '{52,  1'b1, 8'h80};
    vecs[10] = '{56,  1'b0, 8'h80};
    vecs[11] = '{60,  1'b1, 8'h40};
    vecs[12] = '{68,  1'b1, 8'h20};
    vecs[13] = '{108, 1'b1, 8'h01};
    vecs[14] = '{116, 1'b1, 8'h02};
    vecs[15] = '{124, 1'b1, 8'h04};

    // Reset hold across several clock edges.
    start = 1'b0;
    #5;
    check("rst_clk_a", clk_1hz, 0);
    check("rst_led_a", led, 8'h01);
    #20;
    check("rst_clk_b", clk_1hz, 0);
    check("rst_led_b", led, 8'h01);
    #20;
    check("rst_clk_c", clk_1hz, 0);
    check("rst_led_c", led, 8'h01);
    #5;
    start = 1'b1;

    // Run 2 full chaser periods plus a bit, checking model and table each edge.
    for (int e = 1; e <= 240; e++) begin
      @(posedge clk_50mhz);
      #1;
      check("onehot", $countones(led), 1);
      check("clk_model", clk_1hz, exp_clk_at(e));
      check("led_model", led, exp_led_at(e));
      for (int v = 0; v < 16; v++) begin
        if (vecs[v].edge_n == e) begin
          check($sformatf("vec%0d_clk", v), clk_1hz, vecs[v].exp_clk);
          check($sformatf("vec%0d_led", v), led, vecs[v].exp_led);
        end
      end
    end

    // Restart, run until led = 10 (edges 28..35), then reset between edges.
    @(negedge clk_50mhz);
    start = 1'b0;
    #1;
    @(negedge clk_50mhz);
    start = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk_50mhz);
    end
    #1;
    check("mid_led_pre", led, 8'h10);
    check("mid_clk_pre", clk_1hz, 1);
    #4;
    start = 1'b0;
    #1;
    check("mid_led_rst", led, 8'h01);
    check("mid_clk_rst", clk_1hz, 0);
    @(negedge clk_50mhz);
    start = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk_50mhz);
      #1;
      check($sformatf("restart_clk_e%0d", e), clk_1hz, (e == 4) ? 1 : 0);
      check($sformatf("restart_led_e%0d", e), led, (e == 4) ? 8'h02 : 8'h01);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
